// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and constants for the perceptron stream loader
package nn_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] PH_PARAM = 2'd0;
    localparam logic [1:0] PH_INPUT = 2'd1;
    localparam logic [1:0] PH_RUN   = 2'd2;
    localparam logic [1:0] PH_OUT   = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_P,
        ST_ADV_P,
        ST_LOAD_I,
        ST_ADV_I,
        ST_RUN,
        ST_ADV_R,
        ST_CAPT,
        ST_ADV_O
    } state_t;

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        return ph + 2'd1;
    endfunction

endpackage

// File: rtl/nn_phase_tracker.sv
// rtl/nn_phase_tracker.sv - 2-bit phase counter mirroring the network's 4-phase machine
module nn_phase_tracker
    import nn_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [1:0] phase
);

    // Steps on the same edge that the network sees the changes pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH_PARAM;
        end else if (advance) begin
            phase <= next_phase(phase);
        end
    end

endmodule

// File: rtl/nn_stream_loader.sv
// rtl/nn_stream_loader.sv - byte-serial loader sequencing params, inputs, run and capture
module nn_stream_loader
    import nn_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int N_PARAMS   = 6,
    parameter int N_INPUTS   = 4,
    parameter int RUN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              changes,
    output logic [1:0]        phase,
    input  logic [DATA_W-1:0] result_in,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy
);

    localparam logic [7:0] LAST_P = 8'(N_NEURONS * N_PARAMS - 1);
    localparam logic [7:0] LAST_I = 8'(N_INPUTS - 1);
    localparam logic [7:0] LAST_R = 8'(RUN_CYCLES - 1);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nx;
    logic [DATA_W-1:0] data_nx;
    logic [DATA_W-1:0] result_nx;
    logic              dv_nx;
    logic              chg_nx;
    logic              rv_nx;

    assign src_ready = (state == ST_LOAD_P) || (state == ST_LOAD_I);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        data_nx   = data_out;
        result_nx = result;
        dv_nx     = 1'b0;
        chg_nx    = 1'b0;
        rv_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_LOAD_P;
                    cnt_nx   = 8'd0;
                end
            end
            ST_LOAD_P: begin
                if (src_valid) begin
                    data_nx = src_data;
                    dv_nx   = 1'b1;
                    cnt_nx  = cnt + 8'd1;
                    if (cnt == LAST_P) begin
                        state_nx = ST_ADV_P;
                    end
                end
            end
            ST_ADV_P: begin
                chg_nx   = 1'b1;
                cnt_nx   = 8'd0;
                state_nx = ST_LOAD_I;
            end
            ST_LOAD_I: begin
                if (src_valid) begin
                    data_nx = src_data;
                    dv_nx   = 1'b1;
                    cnt_nx  = cnt + 8'd1;
                    if (cnt == LAST_I) begin
                        state_nx = ST_ADV_I;
                    end
                end
            end
            ST_ADV_I: begin
                chg_nx   = 1'b1;
                cnt_nx   = 8'd0;
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                cnt_nx = cnt + 8'd1;
                if (cnt == LAST_R) begin
                    state_nx = ST_ADV_R;
                end
            end
            ST_ADV_R: begin
                chg_nx   = 1'b1;
                cnt_nx   = 8'd0;
                state_nx = ST_CAPT;
            end
            ST_CAPT: begin
                result_nx = result_in;
                rv_nx     = 1'b1;
                state_nx  = ST_ADV_O;
            end
            ST_ADV_O: begin
                chg_nx   = 1'b1;
                cnt_nx   = 8'd0;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            changes      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            data_out     <= data_nx;
            data_valid   <= dv_nx;
            changes      <= chg_nx;
            result       <= result_nx;
            result_valid <= rv_nx;
            busy         <= (state_nx != ST_IDLE);
        end
    end

    // Phase follows the registered pulse, so it reads the network's phase, not a forecast.
    nn_phase_tracker u_phase (
        .clk     (clk),
        .reset   (reset),
        .advance (changes),
        .phase   (phase)
    );

endmodule

// File: doc/nn_stream_loader.md
# nn_stream_loader

Byte-serial transmitter that drives the perceptron network's load interface: it accepts bytes from an upstream source over a valid/ready handshake, presents them on the network's 8-bit data bus, and pulses `changes` to advance the network's 4-phase machine. It sequences parameter load, input load, run wait and result capture, then returns the network to phase 0. It sits between the host/ROM byte source and the `data_in`/`changes` pins of the network top.

## Interface
- `N_NEURONS`, 4: neurons in the layer.
- `N_PARAMS`, 6: bytes per neuron, in order w0, w1, w2, w3, bias, threshold.
- `N_INPUTS`, 4: input bytes per inference.
- `RUN_CYCLES`, 4: cycles held in the run phase before capture; legal range 1..255.

- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high; shared with the network.
- `start` in 1: begin one full sequence; sampled only in IDLE.
- `src_valid` in 1: upstream byte valid.
- `src_data` in 8: upstream byte.
- `src_ready` out 1: loader accepts a byte this cycle.
- `data_out` out 8: byte to the network `data_in`.
- `data_valid` out 1: `data_out` holds a new byte this cycle.
- `changes` out 1: one-cycle pulse that advances the network phase.
- `phase` out 2: mirror of the network phase (0 params, 1 inputs, 2 run, 3 output).
- `result_in` in 8: network `final_output`.
- `result` out 8: captured inference result.
- `result_valid` out 1: one-cycle strobe when `result` updates.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE → LOAD_P → ADV_P → LOAD_I → ADV_I → RUN → ADV_R → CAPT → ADV_O → IDLE.
- IDLE: all strobes 0. On `start`, go to LOAD_P with byte counter 0.
- LOAD_P: `src_ready`=1. Each `src_valid & src_ready` copies `src_data` to `data_out`, sets `data_valid` and increments the counter. After transfer N_NEURONS·N_PARAMS−1 (23 at defaults), go to ADV_P. A low `src_valid` stalls the state; `data_valid`=0 during a stall.
- ADV_x states: `src_ready`=0. Pulse `changes` for one cycle, increment `phase` modulo 4, clear the counter, then move to the next state.
- LOAD_I: same as LOAD_P, for N_INPUTS bytes.
- RUN: count RUN_CYCLES cycles, then go to ADV_R.
- CAPT: register `result_in` into `result`, pulse `result_valid`, go to ADV_O. ADV_O wraps `phase` from 3 to 0.
- `start` while `busy` is ignored. `src_valid` while `src_ready`=0 is not a transfer.
- The counter is 8 bits wide and is compared with `==`. It never wraps within a phase.

## Timing
- Reset values: `src_ready`=0, `data_out`=0, `data_valid`=0, `changes`=0, `phase`=0, `result`=0, `result_valid`=0, `busy`=0, state IDLE.
- All outputs are registered except `src_ready`, which is decoded from the state.
- A handshake accepted in cycle t produces `data_out`/`data_valid` in cycle t+1. `data_out` holds its value when not valid.
- The `changes` pulse comes exactly 1 cycle after the last `data_valid` of a load phase.
- Minimum sequence length from `start` at defaults: 1 + 24 + 1 + 4 + 1 + 4 + 1 + 1 + 1 = 38 cycles, with no stalls.
- `reset` in any state returns to IDLE on the next edge and drops all strobes. The network, on the same reset, returns to phase 0, so `phase` stays consistent.

## Structure
- Shared package `nn_pkg`: state enum, the phase encodings PH_PARAM=0, PH_INPUT=1, PH_RUN=2, PH_OUT=3, and the 8-bit data width constant.
- One sub-module, `nn_phase_tracker`: a 2-bit phase counter that increments on `changes`. The same logic is reused by the bench as a reference model.

## Test plan
- Reset, then `start` with `src_valid` held high and bytes 0x01..0x18 then 0x21..0x24 → `data_out` carries exactly those 28 bytes in order; `changes` pulses after bytes 24 and 28, then after run, after capture; `phase` reads 0,1,2,3,0.
- Same sequence with `src_valid` low for 3 cycles after byte 10 → `data_valid` is low for 3 cycles, no byte is duplicated or lost, and the sequence completes 3 cycles later (41 cycles).
- `result_in`=0x5A during CAPT → `result`=0x5A with `result_valid` high for exactly 1 cycle. `result` holds its value through the next IDLE.
- `start` pulsed during LOAD_I → ignored; byte count and `phase` are unchanged.
- `reset` asserted at byte 12 of LOAD_P → next cycle all outputs are at reset values; a fresh `start` reloads from byte 0 with `phase`=0.
- `RUN_CYCLES`=1 → RUN lasts 1 cycle; total sequence is 35 cycles.
